// File: rtl/i2c_pkg.sv
// Shared definitions for the AXI-Stream I2C target: FSM states and bus bit encodings.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_slv_state_t;

  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit counter runs 0..8; the 8th SCL rise completes a byte.
  localparam int unsigned   BitCntW = 4;
  localparam logic [3:0]    LastBit = 4'd8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge detection and START/STOP condition pulses.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus is high on both lines, so reset to 1 to avoid spurious edges.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/axis_i2c_slave.sv
// I2C target bridging bus writes to m_axis and serving bus reads from s_axis.
module axis_i2c_slave
  import i2c_pkg::*;
#(
  parameter int unsigned MAIN_CLK    = 100_000_000,
  parameter int unsigned I2C_CLK     = 200_000,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       en_i,
  input  logic       i2c_scl_i,
  inout  wire        i2c_sda_io,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy_o,
  output logic       ovf_o,
  output logic       udf_o
);

  if (MAIN_CLK / I2C_CLK < 16) begin : gen_ratio_check
    $error("axis_i2c_slave: MAIN_CLK/I2C_CLK must be at least 16");
  end
  if (SYNC_STAGES < 2) begin : gen_sync_check
    $error("axis_i2c_slave: SYNC_STAGES must be at least 2");
  end

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .scl_i     (i2c_scl_i),
    .sda_i     (i2c_sda_io),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (bus_start),
    .stop_o    (bus_stop)
  );

  i2c_slv_state_t       state_q, state_d;
  logic [BitCntW-1:0]   cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rw_q, rw_d;
  logic                 mack_q, mack_d;
  logic                 drive_q, drive_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 busy_q, busy_d;
  logic                 load_rd;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    rw_d          = rw_q;
    mack_d        = mack_q;
    drive_d       = drive_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    busy_d        = busy_q;
    ovf_o         = 1'b0;
    udf_o         = 1'b0;
    s_axis_tready = 1'b0;
    load_rd       = 1'b0;

    if (hold_vld_q && m_axis_tready) begin
      hold_vld_d = 1'b0;
    end

    if (bus_stop) begin
      state_d = IDLE;
      drive_d = 1'b0;
      busy_d  = 1'b0;
    end else if (bus_start) begin
      state_d = ADDR;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && cnt_q != LastBit) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == LastBit) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              drive_d = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            drive_d = 1'b0;
            if (rw_q == I2C_RD) begin
              load_rd = 1'b1;
            end else begin
              state_d = WR_DATA;
              cnt_d   = '0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && cnt_q != LastBit) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == LastBit) begin
            state_d = WR_ACK;
            // Occupancy is judged on the registered flag, so a same-clk drain still NACKs.
            if (!hold_vld_q) begin
              hold_d     = shift_q;
              hold_vld_d = 1'b1;
              drive_d    = 1'b1;
            end else begin
              ovf_o = 1'b1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_DATA;
            cnt_d   = '0;
            drive_d = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_rise && cnt_q != LastBit) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == LastBit) begin
              state_d = RD_ACK;
              drive_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              drive_d = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall) begin
            if (mack_q == I2C_ACK) begin
              load_rd = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Shared by the address ACK and each master ACK: fetch the next read byte.
    if (load_rd) begin
      state_d = RD_DATA;
      cnt_d   = '0;
      if (s_axis_tvalid) begin
        shift_d       = s_axis_tdata;
        drive_d       = ~s_axis_tdata[7];
        s_axis_tready = 1'b1;
      end else begin
        shift_d = 8'hFF;
        drive_d = 1'b0;
        udf_o   = 1'b1;
      end
    end

    if (!(arstn_i && en_i)) begin
      state_d       = IDLE;
      cnt_d         = '0;
      shift_d       = '0;
      rw_d          = I2C_WR;
      mack_d        = I2C_NACK;
      drive_d       = 1'b0;
      hold_d        = '0;
      hold_vld_d    = 1'b0;
      busy_d        = 1'b0;
      ovf_o         = 1'b0;
      udf_o         = 1'b0;
      s_axis_tready = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rw_q       <= I2C_WR;
      mack_q     <= I2C_NACK;
      drive_q    <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      drive_q    <= drive_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign i2c_sda_io    = drive_q ? 1'b0 : 1'bz;
  assign m_axis_tdata  = hold_q;
  assign m_axis_tvalid = hold_vld_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_axis_i2c_slave.sv
// Bench for axis_i2c_slave: behavioural I2C master, m_axis scoreboard, s_axis feeder.
`timescale 1ns/1ps
module tb_axis_i2c_slave;

  localparam int unsigned MainClk = 100_000_000;
  localparam int unsigned I2cClk  = 2_000_000;
  localparam time         Q       = 125;  // quarter SCL period

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       en = 1'b1;
  logic       scl = 1'b1;
  logic       mst_low = 1'b0;
  wire        sda;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       busy, ovf, udf;

  pullup (sda);
  assign sda = mst_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  axis_i2c_slave #(
    .MAIN_CLK   (MainClk),
    .I2C_CLK    (I2cClk),
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .en_i         (en),
    .i2c_scl_i    (scl),
    .i2c_sda_io   (sda),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .busy_o       (busy),
    .ovf_o        (ovf),
    .udf_o        (udf)
  );

  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0, udf_cnt = 0, hs_cnt = 0, tval_cnt = 0, drive_cnt = 0;
  logic [7:0] exp_m[$];
  logic [7:0] s_q[$];
  logic       s_pop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: m_axis scoreboard, pulse counters, s_axis feeder.
  always @(negedge clk) begin
    if (arstn) begin
      if (ovf) ovf_cnt++;
      if (udf) udf_cnt++;
      if (m_tvalid) tval_cnt++;
      if (!mst_low && sda === 1'b0) drive_cnt++;
      if (m_tvalid && m_tready) begin
        if (exp_m.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_axis_extra: got %0h expected no byte", m_tdata);
        end else begin
          check("m_axis_byte", {24'h0, m_tdata}, {24'h0, exp_m.pop_front()});
        end
      end
    end
    if (s_pop) begin
      void'(s_q.pop_front());
      s_pop = 1'b0;
    end
    if (s_tvalid && s_tready) begin
      hs_cnt++;
      s_pop = 1'b1;
    end else begin
      s_tvalid = (s_q.size() > 0);
      s_tdata  = s_tvalid ? s_q[0] : 8'h00;
    end
  end

  task automatic bit_out(input logic b);
    mst_low = ~b;
    #Q scl = 1'b1;
    #(2 * Q) scl = 1'b0;
    #Q;
  endtask

  task automatic bit_in(output logic b);
    mst_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    mst_low = 1'b0;
    #Q scl = 1'b1;
    #Q mst_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    mst_low = 1'b1;
    #Q scl = 1'b1;
    #Q mst_low = 1'b0;
    #(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(mack);
  endtask

  task automatic clr_counts;
    ovf_cnt = 0; udf_cnt = 0; hs_cnt = 0; tval_cnt = 0; drive_cnt = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_m.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_m.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;

    repeat (4) @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_sda", sda, 1);
    arstn = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // 1: plain write
    clr_counts();
    exp_m.push_back(8'h12);
    exp_m.push_back(8'h34);
    i2c_start();
    wr_byte(8'hA0, ack); check("t1_addr_ack", ack, 0);
    check("t1_busy", busy, 1);
    wr_byte(8'h12, ack); check("t1_d0_ack", ack, 0);
    wr_byte(8'h34, ack); check("t1_d1_ack", ack, 0);
    i2c_stop();
    check("t1_busy_after_stop", busy, 0);
    drain("t1_drain");

    // 2: wrong address
    clr_counts();
    i2c_start();
    wr_byte(8'hA2, ack); check("t2_addr_nack", ack, 1);
    check("t2_busy", busy, 0);
    wr_byte(8'h99, ack);
    i2c_stop();
    check("t2_drive_cnt", drive_cnt, 0);
    check("t2_tvalid_cnt", tval_cnt, 0);

    // 3: read from preloaded s_axis
    clr_counts();
    s_q.push_back(8'hA5);
    s_q.push_back(8'h3C);
    #(4 * Q);
    i2c_start();
    wr_byte(8'hA1, ack); check("t3_addr_ack", ack, 0);
    rd_byte(1'b0, d); check("t3_rd0", d, 8'hA5);
    rd_byte(1'b1, d); check("t3_rd1", d, 8'h3C);
    i2c_stop();
    check("t3_handshakes", hs_cnt, 2);
    check("t3_udf", udf_cnt, 0);

    // 4: holding register overflow
    clr_counts();
    m_tready = 1'b0;
    exp_m.push_back(8'h11);
    i2c_start();
    wr_byte(8'hA0, ack); check("t4_addr_ack", ack, 0);
    wr_byte(8'h11, ack); check("t4_d0_ack", ack, 0);
    wr_byte(8'h22, ack); check("t4_d1_nack", ack, 1);
    i2c_stop();
    check("t4_ovf", ovf_cnt, 1);
    check("t4_held_valid", m_tvalid, 1);
    check("t4_held_data", m_tdata, 8'h11);
    m_tready = 1'b1;
    drain("t4_drain");
    #(4 * Q);
    check("t4_empty", m_tvalid, 0);

    // 5: write, repeated start, underflow read
    clr_counts();
    exp_m.push_back(8'h55);
    i2c_start();
    wr_byte(8'hA0, ack); check("t5_addr_ack", ack, 0);
    wr_byte(8'h55, ack); check("t5_d0_ack", ack, 0);
    i2c_start();
    wr_byte(8'hA1, ack); check("t5_raddr_ack", ack, 0);
    rd_byte(1'b1, d); check("t5_rd", d, 8'hFF);
    i2c_stop();
    check("t5_udf", udf_cnt, 1);
    check("t5_handshakes", hs_cnt, 0);
    drain("t5_drain");

    // 6: reset during bit 4 of a data byte
    clr_counts();
    i2c_start();
    wr_byte(8'hA0, ack); check("t6_addr_ack", ack, 0);
    bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    mst_low = 1'b0;
    #Q scl = 1'b1;
    #Q;
    check("t6_busy_before", busy, 1);
    @(negedge clk) arstn = 1'b0;
    @(negedge clk);
    check("t6_sda", sda, 1);
    check("t6_tvalid", m_tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_s_tready", s_tready, 0);
    check("t6_ovf", ovf, 0);
    check("t6_udf", udf, 0);
    @(negedge clk) arstn = 1'b1;
    @(posedge clk);
    #2 scl = 1'b0;
    #Q;
    bit_out(1'b0); bit_out(1'b1); bit_out(1'b1); bit_out(1'b1);
    bit_in(ack);
    i2c_stop();
    exp_m.push_back(8'h77);
    i2c_start();
    wr_byte(8'hA0, ack); check("t6_re_addr_ack", ack, 0);
    wr_byte(8'h77, ack); check("t6_re_d0_ack", ack, 0);
    i2c_stop();
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
